// File: rtl/key_entry_ctrl_pkg.sv
// Shared definitions for the keypad entry controller: key codes, operator
// codes, FSM state encoding and key classification helpers.
package key_entry_ctrl_pkg;

    localparam int MAX_DIGITS_DEF = 9;

    localparam logic [3:0] KEY_ADD  = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'hB;
    localparam logic [3:0] KEY_MUL  = 4'hC;
    localparam logic [3:0] KEY_DIV  = 4'hD;
    localparam logic [3:0] KEY_EQ   = 4'hE;
    localparam logic [3:0] KEY_SIGN = 4'hF;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        S_OP1  = 3'd0,
        S_OPR  = 3'd1,
        S_OP2  = 3'd2,
        S_WAIT = 3'd3,
        S_RES  = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

    function automatic logic is_op_key(input logic [3:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

    // Operator keys A..D map onto OP_ADD..OP_DIV; anything else is OP_NONE.
    function automatic op_t key_to_op(input logic [3:0] key);
        case (key)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_DIV: return OP_DIV;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/key_entry_ctrl_bcd_acc.sv
// Operand entry buffer: sign + 31-bit magnitude with a significant-digit count.
// clear together with toggle yields a negative zero (used for "F" as the first
// key of a new operand).
module key_entry_ctrl_bcd_acc #(
    parameter int MAX_DIGITS = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_load_digit,
    input  logic        i_append,
    input  logic        i_toggle,
    input  logic [3:0]  i_digit,
    output logic [31:0] o_value
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    logic [30:0] r_buffer;
    logic        r_sign;
    logic [3:0]  r_count;
    logic [31:0] w_mag;

    // Buffer, sign and digit count update; leading zeros do not count as digits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buffer <= '0;
            r_sign   <= 1'b0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_buffer <= '0;
            r_count  <= '0;
            r_sign   <= i_toggle;
        end else if (i_load_digit) begin
            r_buffer <= {27'd0, i_digit};
            r_sign   <= 1'b0;
            r_count  <= (i_digit != 4'd0) ? 4'd1 : 4'd0;
        end else begin
            if (i_append && (r_count < MAX_CNT)) begin
                r_buffer <= (r_buffer * 31'd10) + {27'd0, i_digit};
                if (!((r_buffer == '0) && (i_digit == 4'd0)))
                    r_count <= r_count + 4'd1;
            end
            if (i_toggle)
                r_sign <= ~r_sign;
        end
    end

    // Signed view of the buffer; negative zero reads as zero.
    always_comb begin
        w_mag   = {1'b0, r_buffer};
        o_value = r_sign ? (32'd0 - w_mag) : w_mag;
    end

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad consumer: assembles operands from key strobes, hands operand pairs to
// the calculate unit and chains its result back in as the next left operand.
//
// state  | meaning
// S_OP1  | entering the left operand
// S_OPR  | operator chosen, waiting for the first key of the right operand
// S_OP2  | entering the right operand
// S_WAIT | calculation in flight, keys dropped
// S_RES  | result shown, may chain, repeat (E) or start over
module key_entry_ctrl
    import key_entry_ctrl_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int CALC_LAT   = 1
) (
    input  logic        i_sw_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_ebcd,
    input  logic        i_key_valid,
    input  logic [31:0] i_ans,
    output logic [31:0] o_operand1,
    output logic [31:0] o_operand2,
    output logic [2:0]  o_operator,
    output logic        o_calc_start,
    output logic [31:0] o_disp_value
);

    localparam logic [3:0] LAT_INIT = 4'(CALC_LAT);

    state_t      r_state;
    op_t         r_operator;
    op_t         r_pending;
    logic [31:0] r_operand1;
    logic [31:0] r_operand2;
    logic [31:0] r_disp;
    logic        r_calc_start;
    logic [3:0]  r_timer;

    logic        w_clear;
    logic        w_load_digit;
    logic        w_append;
    logic        w_toggle;
    logic [31:0] w_value;
    logic        w_digit;
    logic        w_op;
    logic        w_eq;
    logic        w_sign;

    key_entry_ctrl_bcd_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc (
        .i_clk        (i_sw_clk),
        .i_rst        (i_rst),
        .i_clear      (w_clear),
        .i_load_digit (w_load_digit),
        .i_append     (w_append),
        .i_toggle     (w_toggle),
        .i_digit      (i_ebcd),
        .o_value      (w_value)
    );

    // Decode the accepted key into buffer commands for the current state.
    always_comb begin
        w_digit      = is_digit(i_ebcd);
        w_op         = is_op_key(i_ebcd);
        w_eq         = (i_ebcd == KEY_EQ);
        w_sign       = (i_ebcd == KEY_SIGN);
        w_clear      = 1'b0;
        w_load_digit = 1'b0;
        w_append     = 1'b0;
        w_toggle     = 1'b0;
        if (i_key_valid) begin
            case (r_state)
                S_OP1, S_OP2: begin
                    w_append = w_digit;
                    w_toggle = w_sign;
                end
                S_OPR: begin
                    w_load_digit = w_digit;
                    w_clear      = w_sign;
                    w_toggle     = w_sign;
                end
                S_RES: w_load_digit = w_digit;
                default: ;
            endcase
        end
    end

    // Main FSM with registered operand, operator, start and display outputs.
    always_ff @(posedge i_sw_clk) begin
        if (i_rst) begin
            r_state      <= S_OP1;
            r_operator   <= OP_NONE;
            r_pending    <= OP_NONE;
            r_operand1   <= '0;
            r_operand2   <= '0;
            r_disp       <= '0;
            r_calc_start <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_calc_start <= 1'b0;
            r_disp       <= ((r_state == S_OP1) || (r_state == S_OP2)) ? w_value : r_operand1;
            case (r_state)
                S_OP1: begin
                    if (i_key_valid && w_op) begin
                        r_operand1 <= w_value;
                        r_operator <= key_to_op(i_ebcd);
                        r_state    <= S_OPR;
                    end
                end
                S_OPR: begin
                    if (i_key_valid) begin
                        if (w_digit || w_sign)
                            r_state <= S_OP2;
                        else if (w_op)
                            r_operator <= key_to_op(i_ebcd);
                    end
                end
                S_OP2: begin
                    if (i_key_valid && (w_eq || w_op)) begin
                        r_operand2   <= w_value;
                        r_calc_start <= 1'b1;
                        r_timer      <= LAT_INIT;
                        r_pending    <= w_eq ? OP_NONE : key_to_op(i_ebcd);
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_timer == 4'd0) begin
                        r_operand1 <= i_ans;
                        r_disp     <= i_ans;
                        if (r_pending != OP_NONE) begin
                            r_operator <= r_pending;
                            r_state    <= S_OPR;
                        end else begin
                            r_state <= S_RES;
                        end
                    end else begin
                        r_timer <= r_timer - 4'd1;
                    end
                end
                S_RES: begin
                    if (i_key_valid) begin
                        if (w_digit) begin
                            r_operator <= OP_NONE;
                            r_state    <= S_OP1;
                        end else if (w_op) begin
                            r_operator <= key_to_op(i_ebcd);
                            r_state    <= S_OPR;
                        end else if (w_sign) begin
                            r_operand1 <= 32'd0 - r_operand1;
                        end else begin
                            r_calc_start <= 1'b1;
                            r_timer      <= LAT_INIT;
                            r_pending    <= OP_NONE;
                            r_state      <= S_WAIT;
                        end
                    end
                end
                default: r_state <= S_OP1;
            endcase
        end
    end

    assign o_operand1   = r_operand1;
    assign o_operand2   = r_operand2;
    assign o_operator   = r_operator;
    assign o_calc_start = r_calc_start;
    assign o_disp_value = r_disp;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl with a latency-1 registered ALU standing in
// for the calculate unit.
module tb_key_entry_ctrl;
    import key_entry_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  ebcd;
    logic        key_valid;
    logic [31:0] ans;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [2:0]  operator;
    logic        calc_start;
    logic [31:0] disp_value;

    int n_chk = 0;
    int n_err = 0;
    int n_start = 0;
    int n_b2b = 0;
    logic prev_start = 1'b0;
    int a_s, b_s;

    key_entry_ctrl #(.MAX_DIGITS(9), .CALC_LAT(1)) dut (
        .i_sw_clk     (clk),
        .i_rst        (rst),
        .i_ebcd       (ebcd),
        .i_key_valid  (key_valid),
        .i_ans        (ans),
        .o_operand1   (operand1),
        .o_operand2   (operand2),
        .o_operator   (operator),
        .o_calc_start (calc_start),
        .o_disp_value (disp_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Calculate stand-in: ans valid one cycle after calc_start.
    always @(posedge clk) begin
        if (calc_start) begin
            a_s = $signed(operand1);
            b_s = $signed(operand2);
            case (operator)
                3'd1: ans <= 32'(a_s + b_s);
                3'd2: ans <= 32'(a_s - b_s);
                3'd3: ans <= 32'(a_s * b_s);
                3'd4: ans <= (b_s == 0) ? 32'd0 : 32'(a_s / b_s);
                default: ans <= 32'd0;
            endcase
        end
        if (calc_start) n_start++;
        if (calc_start && prev_start) n_b2b++;
        prev_start = calc_start;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic press(input logic [3:0] k);
        ebcd      = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        settle(2);
        rst = 1'b0;
        n_start = 0;
    endtask

    initial begin
        rst = 1'b1;
        ebcd = 4'd0;
        key_valid = 1'b0;
        ans = 32'd0;
        settle(3);
        chk("rst_op1", operand1, 32'd0);
        chk("rst_op2", operand2, 32'd0);
        chk("rst_opr", 32'(operator), 32'd0);
        chk("rst_disp", disp_value, 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(S_OP1));

        // 1: plain digit entry
        do_reset();
        press(4'd1); press(4'd2); press(4'd3);
        settle(2);
        chk("t1_disp", disp_value, 32'd123);
        chk("t1_opr", 32'(operator), 32'd0);
        chk("t1_nostart", 32'(n_start), 32'd0);

        // 2: 12 + 34
        do_reset();
        press(4'd1); press(4'd2); press(KEY_ADD); press(4'd3); press(4'd4); press(KEY_EQ);
        chk("t2_op1", operand1, 32'd12);
        chk("t2_opr", 32'(operator), 32'd1);
        chk("t2_op2", operand2, 32'd34);
        settle(3);
        chk("t2_starts", 32'(n_start), 32'd1);
        chk("t2_res", operand1, 32'd46);
        chk("t2_disp", disp_value, 32'd46);
        chk("t2_state", 32'(dut.r_state), 32'(S_RES));

        // 3: digit limit, then leading zeros on a fresh operand
        do_reset();
        for (int i = 0; i < 10; i++) press(4'd9);
        settle(2);
        chk("t3_max", disp_value, 32'd999999999);
        press(KEY_ADD); press(4'd0); press(4'd0);
        settle(2);
        chk("t3_op1", operand1, 32'd999999999);
        chk("t3_zero", disp_value, 32'd0);
        chk("t3_cnt", 32'(dut.u_acc.r_count), 32'd0);

        // 4: -5 * 3, then negate result
        do_reset();
        press(4'd5); press(KEY_SIGN); press(KEY_MUL); press(4'd3); press(KEY_EQ);
        chk("t4_op1", operand1, -32'sd5);
        chk("t4_opr", 32'(operator), 32'd3);
        chk("t4_op2", operand2, 32'd3);
        settle(3);
        chk("t4_res", operand1, -32'sd15);
        press(KEY_SIGN);
        settle(2);
        chk("t4_neg", disp_value, 32'd15);

        // 5: chain 2+3 *4 = 20, repeat = 80
        do_reset();
        press(4'd2); press(KEY_ADD); press(4'd3); press(KEY_MUL);
        settle(3);
        chk("t5_chain_op1", operand1, 32'd5);
        chk("t5_chain_opr", 32'(operator), 32'd3);
        chk("t5_chain_st", 32'(dut.r_state), 32'(S_OPR));
        press(4'd4); press(KEY_EQ);
        settle(3);
        chk("t5_res20", operand1, 32'd20);
        press(KEY_EQ);
        chk("t5_rep_op2", operand2, 32'd4);
        settle(3);
        chk("t5_res80", operand1, 32'd80);
        chk("t5_starts", 32'(n_start), 32'd3);

        // 6: key during wait dropped, then reset mid-S_OP2
        do_reset();
        press(4'd1); press(KEY_ADD); press(4'd2); press(KEY_EQ);
        chk("t6_wait", 32'(dut.r_state), 32'(S_WAIT));
        press(4'd7);
        settle(3);
        chk("t6_res", operand1, 32'd3);
        chk("t6_state", 32'(dut.r_state), 32'(S_RES));
        chk("t6_disp", disp_value, 32'd3);
        press(KEY_ADD); press(4'd5);
        chk("t6_op2st", 32'(dut.r_state), 32'(S_OP2));
        rst = 1'b1;
        @(negedge clk);
        chk("t6_r_op1", operand1, 32'd0);
        chk("t6_r_op2", operand2, 32'd0);
        chk("t6_r_opr", 32'(operator), 32'd0);
        chk("t6_r_start", 32'(calc_start), 32'd0);
        chk("t6_r_disp", disp_value, 32'd0);
        chk("t6_r_state", 32'(dut.r_state), 32'(S_OP1));
        rst = 1'b0;
        settle(1);

        chk("no_b2b_start", 32'(n_b2b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
